// File: rtl/lfsr_pkg.sv
// Shared LFSR definitions: maximal-length tap masks and a reference next-state function.
// Tap masks use "bit k-1 set means position k feeds back", where position 1 is the MSB.
package lfsr_pkg;

    localparam logic [15:0] TAPS_16 = 16'hD008;        // positions 16,15,13,4
    localparam logic [22:0] TAPS_23 = 23'h420000;      // positions 23,18
    localparam logic [25:0] TAPS_26 = 26'h2000023;     // positions 26,6,2,1
    localparam logic [30:0] TAPS_31 = 31'h48000000;    // positions 31,28
    localparam logic [31:0] TAPS_32 = 32'h80200003;    // positions 32,22,2,1

    localparam int unsigned LFSR_MAX_W = 64;

    // One Fibonacci shift of a width-bit state held in the low bits of a 64-bit word.
    // Position k lives at vector bit width-k, so the new bit enters at the MSB.
    function automatic logic [LFSR_MAX_W-1:0] lfsr_next(
        input logic [LFSR_MAX_W-1:0] state,
        input logic [LFSR_MAX_W-1:0] taps,
        input int unsigned           width = 26
    );
        logic fb;
        fb = 1'b0;
        for (int unsigned k = 1; k <= width; k++) begin
            if (taps[k-1]) fb = fb ^ state[width-k];
        end
        return (state >> 1) | (LFSR_MAX_W'(fb) << (width - 1));
    endfunction

endpackage

// File: rtl/lfsr26_gen.sv
// Fibonacci LFSR with synchronous seed load and automatic recovery from the all-zero state.
// Priority on each edge: rst > load > en > hold.
module lfsr26_gen
    import lfsr_pkg::*;
#(
    parameter int               WIDTH = 26,
    parameter logic [WIDTH-1:0] TAPS  = TAPS_26,
    parameter logic [WIDTH-1:0] SEED  = WIDTH'(1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] din,
    input  logic             en,
    output logic [WIDTH-1:0] q,
    output logic             lockup
);

    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] q_d;
    logic [WIDTH-1:0] tap_bits;
    logic             fb;

    // Position k maps to vector bit WIDTH-k; tap mask bit k-1 selects position k.
    for (genvar k = 1; k <= WIDTH; k++) begin : g_tap
        assign tap_bits[k-1] = TAPS[k-1] & q_q[WIDTH-k];
    end

    assign fb = ^tap_bits;

    always_comb begin
        q_d = q_q;
        if (load) begin
            q_d = din;
        end else if (en) begin
            if (q_q == '0) q_d = SEED;
            else           q_d = {fb, q_q[WIDTH-1:1]};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) q_q <= SEED;
        else     q_q <= q_d;
    end

    assign q      = q_q;
    assign lockup = (q_q == '0);

endmodule

// File: tb/tb_lfsr26_gen.sv
// Directed and randomised checks of lfsr26_gen against hand-computed vectors and a reference model.
module tb_lfsr26_gen;
    import lfsr_pkg::*;

    logic        clk;
    logic        rst;
    logic        load;
    logic [25:0] din;
    logic        en;
    logic [25:0] q;
    logic        lockup;

    int errors = 0;
    int checks = 0;

    logic [25:0] exp_q;

    lfsr26_gen dut (
        .clk    (clk),
        .rst    (rst),
        .load   (load),
        .din    (din),
        .en     (en),
        .q      (q),
        .lockup (lockup)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance one clock and settle just after the edge before sampling.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [25:0] shift26(input logic [25:0] cur);
        logic [63:0] nxt;
        nxt = lfsr_next(64'(cur), 64'(TAPS_26), 26);
        return nxt[25:0];
    endfunction

    function automatic logic [25:0] model(input logic r, input logic ld, input logic e,
                                          input logic [25:0] d, input logic [25:0] cur);
        if (r)              return 26'h0000001;
        else if (ld)        return d;
        else if (!e)        return cur;
        else if (cur == '0) return 26'h0000001;
        else                return shift26(cur);
    endfunction

    initial begin
        rst = 1'b1; load = 1'b1; en = 1'b1; din = 26'h3FFFFFF;
        #1;

        step();
        check("reset_q1", q, 26'h0000001);
        check("reset_lockup1", lockup, 1'b0);
        step();
        check("reset_q2", q, 26'h0000001);

        rst = 1'b0; load = 1'b0; en = 1'b1;
        step();
        check("run1", q, 26'h2000000);
        step();
        check("run2", q, 26'h3000000);

        load = 1'b1; din = 26'h19383F2;
        step();
        check("load", q, 26'h19383F2);
        load = 1'b0;
        step();
        check("shift_fb0", q, 26'h0C9C1F9);

        load = 1'b1; en = 1'b1; din = 26'h0AAAAAA;
        step();
        check("load_over_en", q, 26'h0AAAAAA);
        load = 1'b0; en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            check($sformatf("hold%0d", i), q, 26'h0AAAAAA);
        end

        load = 1'b1; din = 26'h0;
        step();
        check("load_zero_q", q, 26'h0);
        check("load_zero_lockup", lockup, 1'b1);
        load = 1'b0; en = 1'b1;
        step();
        check("recover_q", q, 26'h0000001);
        check("recover_lockup", lockup, 1'b0);

        exp_q = 26'h0000001;
        for (int i = 0; i < 100; i++) begin
            step();
            exp_q = shift26(exp_q);
        end
        check("run100", q, exp_q);
        rst = 1'b1; load = 1'b1; din = 26'h3FFFFFF; en = 1'b1;
        step();
        check("rst_midrun", q, 26'h0000001);
        check("rst_midrun_lockup", lockup, 1'b0);

        exp_q = 26'h0000001;
        for (int i = 0; i < 10000; i++) begin
            rst  = ($urandom_range(0, 199) == 0);
            load = ($urandom_range(0, 15) == 0);
            en   = ($urandom_range(0, 3) != 0);
            din  = ($urandom_range(0, 7) == 0) ? 26'h0 : 26'($urandom());
            exp_q = model(rst, load, en, din, exp_q);
            step();
            check("random_q", q, exp_q);
            check("random_lockup", lockup, exp_q == '0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Safety net so the bench always terminates.
    initial begin
        #2000000;
        errors++;
        $display("FAIL timeout: got no finish expected finish");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "timeout");
    end

endmodule
